// File: rtl/pb_debounce_multi.sv
// rtl/pb_debounce_multi.sv - multi-channel push-button debouncer with edge and long-press pulses
// Optional long-press hold counters are built when PB_LONGPRESS_EN is defined.
module pb_debounce_multi #(
  parameter int N_CH        = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int EDGE_MODE   = 0,
  parameter int LONG_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_pulse,
  output logic [N_CH-1:0] pb_long
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("pb_debounce_multi: N_CH must be 1..32");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("pb_debounce_multi: DEB_CYCLES must be >= 1");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("pb_debounce_multi: EDGE_MODE must be 0, 1 or 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("pb_debounce_multi: LONG_CYCLES must be >= 1");
  end

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] level_q;
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb_in;
      sync2 <= sync1;
    end
  end

  // Counter only runs while sync2 disagrees with the accepted level, so it
  // tops out at DEB_CYCLES-1 and cannot wrap.
  for (genvar i = 0; i < N_CH; i++) begin : g_deb
    logic [CW-1:0] cnt;

    assign load[i] = (sync2[i] != pb_level[i]) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (sync2[i] == pb_level[i] || load[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_level <= '0;
    end else begin
      pb_level <= (pb_level & ~load) | (sync2 & load);
    end
  end

  assign rise = pb_level & ~level_q;
  assign fall = ~pb_level & level_q;

  if (EDGE_MODE == 0) begin : g_sel_rise
    assign sel = rise;
  end else if (EDGE_MODE == 1) begin : g_sel_fall
    assign sel = fall;
  end else begin : g_sel_both
    assign sel = rise | fall;
  end

  // level_q lags pb_level by one cycle, so the pulse lands the cycle after the change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q  <= '0;
      pb_pulse <= '0;
    end else begin
      level_q  <= pb_level;
      pb_pulse <= sel;
    end
  end

`ifdef PB_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_CYCLES - 1);

  logic [N_CH-1:0] long_hit;

  // Saturating at LONG_CYCLES means the hit value is passed only once per press.
  for (genvar i = 0; i < N_CH; i++) begin : g_hold
    logic [HW-1:0] hold;

    assign long_hit[i] = pb_level[i] && (hold == HOLD_HIT);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold <= '0;
      end else if (!pb_level[i]) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_long <= '0;
    end else begin
      pb_long <= long_hit;
    end
  end
`else
  assign pb_long = '0;
`endif

endmodule
